// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: FSM state encoding and address-split helper shared by the instruction cache.
package inst_cache_pkg;
   typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;
   function automatic int offset_w(input int line_words);
      return 2 + $clog2(line_words);
   endfunction
endpackage

// File: rtl/inst_cache_data_array.sv
// inst_cache_data_array: SETS x LINE_WORDS x 32 line storage, one word write port, one async read port.
module inst_cache_data_array #(
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 8,
   parameter int INDEX_W    = $clog2(SETS),
   parameter int WORD_W     = $clog2(LINE_WORDS)
) (
   input  logic               clk,
   input  logic               wen,
   input  logic [INDEX_W-1:0] wr_set,
   input  logic [WORD_W-1:0]  wr_word,
   input  logic [31:0]        wr_data,
   input  logic [INDEX_W-1:0] rd_set,
   input  logic [WORD_W-1:0]  rd_word,
   output logic [31:0]        rd_data
);
   logic [31:0] mem_q [SETS][LINE_WORDS];
   always_ff @(posedge clk) begin
      if (wen) mem_q[wr_set][wr_word] <= wr_data;
   end
   assign rd_data = mem_q[rd_set][rd_word];
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache with burst line refill.
// Define ICACHE_PERF_EN to add Hit_Cnt/Miss_Cnt lookup counters.
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int SETS       = 8,
   parameter int LINE_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst,
`ifdef ICACHE_PERF_EN
   output logic [31:0] Hit_Cnt,
   output logic [31:0] Miss_Cnt,
`endif
   input  logic [31:0] Inst_Req_Addr,
   input  logic        Inst_Req_Valid,
   output logic        Inst_Req_Ready,
   output logic [31:0] Instruction,
   output logic        Inst_Valid,
   input  logic        Inst_Ready,
   output logic [31:0] Mem_Req_Addr,
   output logic        Mem_Req_Valid,
   input  logic        Mem_Req_Ready,
   input  logic [31:0] Mem_Rdata,
   input  logic        Mem_Rdata_Valid,
   input  logic        Mem_Rdata_Last,
   output logic        Mem_Rdata_Ready
);
   localparam int WORD_W   = $clog2(LINE_WORDS);
   localparam int OFFSET_W = offset_w(LINE_WORDS);
   localparam int INDEX_W  = $clog2(SETS);
   localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;

   state_t             state_q, state_d;
   logic [31:2]        addr_q, addr_d;
   logic [31:0]        instr_q, instr_d;
   logic [WORD_W-1:0]  cnt_q, cnt_d;
   logic [SETS-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [SETS];
   logic [TAG_W-1:0]   tag_d [SETS];
   logic [INDEX_W-1:0] idx;
   logic [WORD_W-1:0]  word;
   logic [TAG_W-1:0]   tag;
   logic [31:0]        rd_data;
   logic               hit;
   logic               unused_addr;

   assign unused_addr = ^Inst_Req_Addr[1:0];
   assign idx  = addr_q[OFFSET_W +: INDEX_W];
   assign word = addr_q[2 +: WORD_W];
   assign tag  = addr_q[31 -: TAG_W];
   assign hit  = valid_q[idx] && tag_q[idx] == tag;

   inst_cache_data_array #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_data (
      .clk     (clk),
      .wen     (state_q == REFILL && Mem_Rdata_Valid),
      .wr_set  (idx),
      .wr_word (cnt_q),
      .wr_data (Mem_Rdata),
      .rd_set  (idx),
      .rd_word (word),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      case (state_q)
         IDLE: if (Inst_Req_Valid) begin
            addr_d  = Inst_Req_Addr[31:2];
            state_d = LOOKUP;
         end
         LOOKUP: begin
            instr_d = hit ? rd_data : instr_q;
            state_d = hit ? RESP : MISS;
         end
         MISS: if (Mem_Req_Ready) begin
            cnt_d   = '0;
            state_d = REFILL;
         end
         REFILL: if (Mem_Rdata_Valid) begin
            cnt_d   = cnt_q + 1'b1;
            instr_d = cnt_q == word ? Mem_Rdata : instr_q;
            // Line becomes valid only on the final beat, so an abandoned burst never hits.
            if (Mem_Rdata_Last) begin
               tag_d[idx]   = tag;
               valid_d[idx] = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: state_d = Inst_Ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      tag_q <= tag_d;
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= '0;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   assign hit_cnt_d  = hit_cnt_q + 32'(state_q == LOOKUP && hit);
   assign miss_cnt_d = miss_cnt_q + 32'(state_q == LOOKUP && !hit);
   always_ff @(posedge clk) begin
      hit_cnt_q  <= rst ? '0 : hit_cnt_d;
      miss_cnt_q <= rst ? '0 : miss_cnt_d;
   end
   assign Hit_Cnt  = hit_cnt_q;
   assign Miss_Cnt = miss_cnt_q;
`endif

   assign Inst_Req_Ready  = state_q == IDLE;
   assign Inst_Valid      = state_q == RESP;
   assign Instruction     = instr_q;
   assign Mem_Req_Valid   = state_q == MISS;
   assign Mem_Req_Addr    = Mem_Req_Valid ? {tag, idx, {OFFSET_W{1'b0}}} : '0;
   assign Mem_Rdata_Ready = state_q == REFILL;
endmodule
